crd_sync_ctrl: RTL and testbench

//   Receive-lane sync controller that sequences the 8b/10b running-disparity (CRD) checker.
//   - Holds the checker in reset while hunting, releases it on comma detection.
//   - Qualifies checker err against symbol valid; acquires lane sync on repeated commas.
//   - Drops sync when disparity errors outweigh clean symbols; keeps a saturating error count.

---
 rtl/crd_sync_ctrl_if.sv | 26 ++
 rtl/crd_sync_ctrl.sv | 161 ++++++++++++++++
 tb/tb_crd_sync_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crd_sync_ctrl_if.sv
// Receive-lane symbol stream plus sync-controller status, shared by the lane
// front end (master) and the CRD sync controller (slave).
interface crd_sync_ctrl_if #(
    parameter int unsigned iWIDTH = 10,
    parameter int unsigned CNT_W  = 16
);
    logic              sym_vld;
    logic [iWIDTH-1:0] sym_in;
    logic              dsp_err;
    logic              cnt_clr;
    logic              crd_rst;
    logic              lane_sync;
    logic              sync_lost;
    logic [CNT_W-1:0]  err_cnt;
    logic [1:0]        state;

    modport master (
        output sym_vld, sym_in, dsp_err, cnt_clr,
        input  crd_rst, lane_sync, sync_lost, err_cnt, state
    );

    modport slave (
        input  sym_vld, sym_in, dsp_err, cnt_clr,
        output crd_rst, lane_sync, sync_lost, err_cnt, state
    );
endinterface

// File: rtl/crd_sync_ctrl.sv
// Lane sync controller: hunts for K28.5, sequences the CRD checker reset,
// acquires sync on repeated commas and drops it when disparity errors dominate.
module crd_sync_ctrl #(
    parameter int unsigned       iWIDTH     = 10,
    parameter int unsigned       ACQ_COMMAS = 4,
    parameter int unsigned       ERR_MAX    = 4,
    parameter int unsigned       GOOD_RUN   = 16,
    parameter int unsigned       CNT_W      = 16,
    parameter logic [iWIDTH-1:0] COMMA_N    = 10'b0011111010,
    parameter logic [iWIDTH-1:0] COMMA_P    = 10'b1100000101
) (
    input logic            clk,
    input logic            rst,
    crd_sync_ctrl_if.slave lane
);

    localparam int unsigned CC_W  = $clog2(ACQ_COMMAS + 1);
    localparam int unsigned BAD_W = $clog2(ERR_MAX + 1);
    localparam int unsigned RUN_W = $clog2(GOOD_RUN + 1);

    localparam logic [CC_W-1:0]  ACQ_LAST = CC_W'(ACQ_COMMAS - 1);
    localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(ERR_MAX - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(GOOD_RUN - 1);

    typedef enum logic [1:0] {
        HUNT = 2'b00,
        ACQ  = 2'b01,
        SYNC = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             vld_d1;
    logic             crd_rst_q, crd_rst_d;
    logic             crd_rst_d1, crd_rst_d2;
    logic             lane_sync_q, lane_sync_d;
    logic             sync_lost_q, sync_lost_d;
    logic [CC_W-1:0]  comma_q, comma_d;
    logic [BAD_W-1:0] bad_q, bad_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic comma;
    logic mask;
    logic qerr;
    logic qgood;

    assign comma = lane.sym_vld & ((lane.sym_in == COMMA_N) | (lane.sym_in == COMMA_P));
    // Checker output is untrustworthy for the two cycles after its reset is released.
    assign mask  = ~crd_rst_q & (crd_rst_d1 | crd_rst_d2);
    assign qerr  =  lane.dsp_err & vld_d1 & ~mask;
    assign qgood = ~lane.dsp_err & vld_d1 & ~mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            vld_d1      <= 1'b0;
            crd_rst_q   <= 1'b1;
            crd_rst_d1  <= 1'b1;
            crd_rst_d2  <= 1'b1;
            lane_sync_q <= 1'b0;
            sync_lost_q <= 1'b0;
            comma_q     <= '0;
            bad_q       <= '0;
            run_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            vld_d1      <= lane.sym_vld;
            crd_rst_q   <= crd_rst_d;
            crd_rst_d1  <= crd_rst_q;
            crd_rst_d2  <= crd_rst_d1;
            lane_sync_q <= lane_sync_d;
            sync_lost_q <= sync_lost_d;
            comma_q     <= comma_d;
            bad_q       <= bad_d;
            run_q       <= run_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: begin
                if (comma) begin
                    state_d = (ACQ_COMMAS <= 1) ? SYNC : ACQ;
                end
            end
            ACQ: begin
                if (!lane.sym_vld || qerr) begin
                    state_d = HUNT;
                end else if (comma && (comma_q == ACQ_LAST)) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (!lane.sym_vld || (qerr && (bad_q == BAD_LAST))) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        comma_d = comma_q;
        bad_d   = bad_q;
        run_d   = run_q;
        err_d   = err_q;
        case (state_q)
            HUNT: begin
                if (comma) begin
                    comma_d = CC_W'(1);
                end
            end
            ACQ: begin
                if (comma) begin
                    comma_d = comma_q + 1'b1;
                end
            end
            SYNC: begin
                if (qerr) begin
                    bad_d = bad_q + 1'b1;
                    run_d = '0;
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                end else if (qgood) begin
                    if (run_q == RUN_LAST) begin
                        run_d = '0;
                        if (bad_q != '0) begin
                            bad_d = bad_q - 1'b1;
                        end
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (lane.cnt_clr) begin
            err_d = '0;
        end
        // Any path back to HUNT restarts acquisition and error accounting from scratch.
        if (state_d == HUNT) begin
            comma_d = '0;
            bad_d   = '0;
            run_d   = '0;
        end
        crd_rst_d   = (state_d == HUNT);
        lane_sync_d = (state_d == SYNC);
        sync_lost_d = (state_q == SYNC) && (state_d != SYNC);
    end

    assign lane.crd_rst   = crd_rst_q;
    assign lane.lane_sync = lane_sync_q;
    assign lane.sync_lost = sync_lost_q;
    assign lane.err_cnt   = err_q;
    assign lane.state     = state_q;

endmodule

// File: tb/tb_crd_sync_ctrl.sv
// Scoreboarded bench for crd_sync_ctrl: a 16-bit and a 3-bit err_cnt instance
// share one randomized symbol stream checked against a behavioural lane model.
module tb_crd_sync_ctrl;

    localparam logic [9:0] COMMA_N = 10'b0011111010;
    localparam logic [9:0] COMMA_P = 10'b1100000101;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    crd_sync_ctrl_if #(.iWIDTH(10), .CNT_W(16)) if16 ();
    crd_sync_ctrl_if #(.iWIDTH(10), .CNT_W(3))  if3 ();

    crd_sync_ctrl #(.iWIDTH(10), .CNT_W(16)) u_dut16 (.clk(clk), .rst(rst), .lane(if16));
    crd_sync_ctrl #(.iWIDTH(10), .CNT_W(3))  u_dut3  (.clk(clk), .rst(rst), .lane(if3));

    typedef struct {
        bit crd_rst;
        bit lane_sync;
        bit sync_lost;
        int err16;
        int err3;
        int st;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   pulses16 = 0;
    bit   pend_err = 1'b0;

    // Lane model: mode 0=hunting, 1=acquiring, 2=in sync
    int m_mode, m_commas, m_bad, m_run, m_err16, m_err3, m_low_age;
    bit m_prev_vld, m_crd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit v, input logic [9:0] s,
                              input bit de, input bit cl, output exp_t e);
        bit comma, masked, qe, qg, to_hunt, lost;
        to_hunt = 1'b0;
        lost    = 1'b0;
        if (r) begin
            m_mode = 0; m_commas = 0; m_bad = 0; m_run = 0;
            m_err16 = 0; m_err3 = 0; m_prev_vld = 1'b0; m_crd = 1'b1; m_low_age = 0;
        end else begin
            comma  = v && (s == COMMA_N || s == COMMA_P);
            masked = m_crd || (m_low_age < 2);
            qe = de && m_prev_vld && !masked;
            qg = !de && m_prev_vld && !masked;
            case (m_mode)
                0: if (comma) begin m_commas = 1; m_mode = 1; end
                1: begin
                    if (!v || qe) to_hunt = 1'b1;
                    else if (comma) begin
                        m_commas++;
                        if (m_commas == 4) m_mode = 2;
                    end
                end
                2: begin
                    if (qe) begin
                        m_bad++;
                        m_run = 0;
                        if (m_err16 < 65535) m_err16++;
                        if (m_err3 < 7) m_err3++;
                    end else if (qg) begin
                        m_run++;
                        if (m_run == 16) begin
                            m_run = 0;
                            if (m_bad > 0) m_bad--;
                        end
                    end
                    if (!v || m_bad >= 4) begin to_hunt = 1'b1; lost = 1'b1; end
                end
                default: to_hunt = 1'b1;
            endcase
            if (cl) begin m_err16 = 0; m_err3 = 0; end
            if (to_hunt) begin m_mode = 0; m_commas = 0; m_bad = 0; m_run = 0; end
            m_prev_vld = v;
            if (m_mode == 0) m_crd = 1'b1;
            else if (m_crd) begin m_crd = 1'b0; m_low_age = 0; end
            else if (m_low_age < 2) m_low_age++;
        end
        e.crd_rst   = m_crd;
        e.lane_sync = (m_mode == 2);
        e.sync_lost = lost;
        e.err16     = m_err16;
        e.err3      = m_err3;
        e.st        = m_mode;
    endtask

    // One symbol slot; dsp_err carries the checker verdict on the previous symbol.
    task automatic step(input bit r, input bit v, input logic [9:0] s, input bit bad, input bit cl);
        exp_t e;
        rst = r;
        if16.sym_vld = v;  if16.sym_in = s;  if16.dsp_err = pend_err;  if16.cnt_clr = cl;
        if3.sym_vld  = v;  if3.sym_in  = s;  if3.dsp_err  = pend_err;  if3.cnt_clr  = cl;
        model_step(r, v, s, pend_err, cl, e);
        pend_err = v & bad;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    function automatic logic [9:0] dsym();
        logic [9:0] d;
        d = 10'($urandom);
        if (d == COMMA_N || d == COMMA_P) d = d ^ 10'h001;
        return d;
    endfunction

    function automatic logic [9:0] kcomma(input int i);
        return (i % 2 == 1) ? COMMA_P : COMMA_N;
    endfunction

    task automatic do_reset();
        step(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'h000, 1'b0, 1'b0);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, dsym(), 1'b0, 1'b0);
    endtask

    task automatic errs(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, dsym(), 1'b1, 1'b0);
    endtask

    task automatic acquire();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, kcomma(i), 1'b0, 1'b0);
            if (i == 0) chk("crd_rst_after_comma1", if16.crd_rst, 0);
            if (i == 2) chk("no_sync_before_comma4", if16.lane_sync, 0);
            if (i == 3) chk("sync_after_comma4", if16.lane_sync, 1);
            if (i < 3) clean($urandom_range(0, 2));
        end
        clean(2);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("crd_rst",   if16.crd_rst,   mon_e.crd_rst);
            chk("lane_sync", if16.lane_sync, mon_e.lane_sync);
            chk("sync_lost", if16.sync_lost, mon_e.sync_lost);
            chk("err_cnt16", if16.err_cnt,   mon_e.err16);
            chk("state",     if16.state,     mon_e.st);
            chk("err_cnt3",  if3.err_cnt,    mon_e.err3);
            chk("state3",    if3.state,      mon_e.st);
        end
        if (if16.sync_lost === 1'b1) pulses16++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b1;
        if16.sym_vld = 1'b0; if16.sym_in = '0; if16.dsp_err = 1'b0; if16.cnt_clr = 1'b0;
        if3.sym_vld  = 1'b0; if3.sym_in  = '0; if3.dsp_err  = 1'b0; if3.cnt_clr  = 1'b0;
        @(posedge clk); #1;

        // Reset values and clean acquisition
        do_reset();
        chk("rst_crd_rst", if16.crd_rst, 1);
        chk("rst_state", if16.state, 0);
        chk("rst_err_cnt", if16.err_cnt, 0);
        acquire();
        clean(10);
        chk("t1_err_cnt", if16.err_cnt, 0);
        chk("t1_state", if16.state, 2);

        // Four back-to-back disparity errors drop sync
        p0 = pulses16;
        errs(4);
        clean(4);
        chk("t2_err_cnt", if16.err_cnt, 4);
        chk("t2_state", if16.state, 0);
        chk("t2_crd_rst", if16.crd_rst, 1);
        chk("t2_lane_sync", if16.lane_sync, 0);
        chk("t2_pulses", pulses16 - p0, 1);

        // Clean runs retire bad counts; sync held
        do_reset();
        p0 = pulses16;
        acquire();
        errs(3);
        clean(48);
        errs(3);
        clean(3);
        chk("t3_lane_sync", if16.lane_sync, 1);
        chk("t3_err_cnt", if16.err_cnt, 6);
        chk("t3_pulses", pulses16 - p0, 0);

        // Valid gap in ACQ restarts the hunt without a sync_lost pulse
        do_reset();
        p0 = pulses16;
        step(1'b0, 1'b1, COMMA_N, 1'b0, 1'b0);
        step(1'b0, 1'b1, COMMA_P, 1'b0, 1'b0);
        step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        chk("t4_state_hunt", if16.state, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, kcomma(i), 1'b0, 1'b0);
        chk("t4_state_acq", if16.state, 1);
        chk("t4_no_sync", if16.lane_sync, 0);
        step(1'b0, 1'b1, COMMA_P, 1'b0, 1'b0);
        clean(2);
        chk("t4_sync", if16.lane_sync, 1);
        chk("t4_pulses", pulses16 - p0, 0);

        // Narrow counter saturates; clear beats a coincident error
        do_reset();
        acquire();
        for (int i = 0; i < 9; i++) begin
            errs(1);
            clean(16);
        end
        chk("t5_err3_sat", if3.err_cnt, 7);
        chk("t5_err16", if16.err_cnt, 9);
        chk("t5_state", if3.state, 2);
        errs(1);
        step(1'b0, 1'b1, dsym(), 1'b0, 1'b1);
        chk("t5_clr3", if3.err_cnt, 0);
        chk("t5_clr16", if16.err_cnt, 0);

        // Reset mid-SYNC alongside a qualified error
        clean(2);
        p0 = pulses16;
        errs(1);
        step(1'b1, 1'b1, dsym(), 1'b0, 1'b0);
        chk("t6_crd_rst", if16.crd_rst, 1);
        chk("t6_lane_sync", if16.lane_sync, 0);
        chk("t6_sync_lost", if16.sync_lost, 0);
        chk("t6_err_cnt", if16.err_cnt, 0);
        chk("t6_state", if16.state, 0);
        step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        chk("t6_pulses", pulses16 - p0, 0);

        // Randomized soak
        for (int i = 0; i < 1500; i++) begin
            logic [9:0] s;
            s = ($urandom_range(0, 2) == 0) ? kcomma(int'($urandom_range(0, 1))) : dsym();
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0, s,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0);
        end

        step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
